// File: rtl/ahb_pkg.sv
// Shared AHB-Lite definitions: transfer/response/size encodings, error FSM states
// and the byte-strobe helper used by the AHB SRAM slaves.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  localparam logic [2:0] HSIZE_BYTE  = 3'd0;
  localparam logic [2:0] HSIZE_HALF  = 3'd1;
  localparam logic [2:0] HSIZE_WORD  = 3'd2;
  localparam logic [2:0] HSIZE_DWORD = 3'd3;
  localparam logic [2:0] HSIZE_QWORD = 3'd4;

  localparam int unsigned BE_MAX = 16;

  typedef enum logic [1:0] {
    ERR_OK,
    ERR_FIRST,
    ERR_SECOND
  } err_state_e;

  // Byte strobes for a transfer of 2^hsize bytes at lane offset 'lane', offset
  // aligned down to the transfer size; oversize transfers enable every lane.
  function automatic logic [BE_MAX-1:0] be_from_size(input logic [2:0]  hsize,
                                                     input logic [3:0]  lane,
                                                     input int unsigned nb_log2);
    int unsigned nbytes;
    int unsigned off;
    int unsigned mask;
    if (32'(hsize) > nb_log2) begin
      mask = (32'd1 << (32'd1 << nb_log2)) - 32'd1;
    end else begin
      nbytes = 32'd1 << hsize;
      off    = 32'(lane) & ~(nbytes - 32'd1);
      mask   = ((32'd1 << nbytes) - 32'd1) << off;
    end
    return mask[BE_MAX-1:0];
  endfunction

endpackage

// File: rtl/ahb_sram_wb_buf.sv
// One-entry write buffer for ahb_sram_wb: drains to the SRAM whenever the port is
// free and captures forward data for reads that hit the pending write.
module ahb_sram_wb_buf import ahb_pkg::*; #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned AW     = 10
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  ld,
  input  logic [AW-1:0]         ld_addr,
  input  logic [DATA_W/8-1:0]   ld_be,
  input  logic [DATA_W-1:0]     ld_data,
  input  logic                  rd_acc,
  input  logic [AW-1:0]         rd_addr,
  output logic                  wr_en,
  output logic [AW-1:0]         wr_addr,
  output logic [DATA_W/8-1:0]   wr_be,
  output logic [DATA_W-1:0]     wr_data,
  output logic [DATA_W/8-1:0]   fwd_be,
  output logic [DATA_W-1:0]     fwd_data
);

  logic                buf_valid;
  logic [AW-1:0]       buf_addr;
  logic [DATA_W/8-1:0] buf_be;
  logic [DATA_W-1:0]   buf_data;

  logic                nxt_valid;
  logic [AW-1:0]       nxt_addr;
  logic [DATA_W/8-1:0] nxt_be;
  logic [DATA_W-1:0]   nxt_data;
  logic                direct;
  logic                hit;

  // An empty buffer lets an incoming write go straight to the SRAM when the port
  // is free; this is what keeps occupancy at one entry across W,W,R sequences.
  assign direct  = ld & ~buf_valid & ~rd_acc;
  assign wr_en   = ~rd_acc & (buf_valid | ld);
  assign wr_addr = buf_valid ? buf_addr : ld_addr;
  assign wr_be   = buf_valid ? buf_be   : ld_be;
  assign wr_data = buf_valid ? buf_data : ld_data;

  always_comb begin
    nxt_valid = buf_valid;
    nxt_addr  = buf_addr;
    nxt_be    = buf_be;
    nxt_data  = buf_data;
    if (ld && !direct) begin
      nxt_valid = 1'b1;
      nxt_addr  = ld_addr;
      nxt_be    = ld_be;
      nxt_data  = ld_data;
    end else if (wr_en) begin
      nxt_valid = 1'b0;
    end
  end

  assign hit = rd_acc & nxt_valid & (nxt_addr == rd_addr);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      buf_valid <= 1'b0;
      buf_addr  <= '0;
      buf_be    <= '0;
      buf_data  <= '0;
      fwd_be    <= '0;
      fwd_data  <= '0;
    end else begin
      buf_valid <= nxt_valid;
      buf_addr  <= nxt_addr;
      buf_be    <= nxt_be;
      buf_data  <= nxt_data;
      fwd_be    <= hit ? nxt_be : '0;
      fwd_data  <= nxt_data;
    end
  end

endmodule

// File: rtl/spram_generic_wbe.sv
// Generic single-port synchronous SRAM with per-byte write enables and
// registered read data (one-cycle read latency).
module spram_generic_wbe #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 1024,
  parameter int unsigned AW     = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic                  we,
  input  logic [DATA_W/8-1:0]   wbe,
  input  logic [AW-1:0]         addr,
  input  logic [DATA_W-1:0]     din,
  output logic [DATA_W-1:0]     dout
);

  localparam int unsigned NB = DATA_W / 8;

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int unsigned i = 0; i < NB; i++) begin
          if (wbe[i]) mem[addr][i*8 +: 8] <= din[i*8 +: 8];
        end
      end else begin
        dout <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/ahb_sram_wb.sv
// AHB-Lite zero-wait SRAM slave with one-entry write buffer and read forwarding.
// Define AHB_SRAM_WB_ERR_EN to return two-cycle ERROR on out-of-range/oversize transfers.
module ahb_sram_wb import ahb_pkg::*; #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned DEPTH   = 1024,
  parameter int unsigned HADDR_W = 32
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               hsel,
  input  logic [HADDR_W-1:0] haddr,
  input  logic [1:0]         htrans,
  input  logic [2:0]         hsize,
  input  logic [2:0]         hburst,
  input  logic [3:0]         hprot,
  input  logic               hwrite,
  input  logic [DATA_W-1:0]  hwdata,
  input  logic               hready,
  output logic               hreadyout,
  output logic               hresp,
  output logic [DATA_W-1:0]  hrdata
);

  localparam int unsigned NB  = DATA_W / 8;
  localparam int unsigned NBL = $clog2(NB);
  localparam int unsigned AW  = $clog2(DEPTH);

  logic [AW-1:0]     idx;
  logic [BE_MAX-1:0] be_full;
  logic [NB-1:0]     be;
  logic              acc_raw;
  logic              acc;
  logic              rd_acc;

  logic              rd_dph;
  logic              wr_dph;
  logic [AW-1:0]     wr_addr;
  logic [NB-1:0]     wr_be;

  logic              sram_en;
  logic              buf_wr_en;
  logic [AW-1:0]     buf_wr_addr;
  logic [NB-1:0]     buf_wr_be;
  logic [DATA_W-1:0] buf_wr_data;
  logic [NB-1:0]     fwd_be;
  logic [DATA_W-1:0] fwd_data;
  logic [DATA_W-1:0] sram_dout;

  logic unused_in;
  assign unused_in = ^{hburst, hprot, haddr};

  assign idx     = haddr[AW+NBL-1:NBL];
  assign be_full = be_from_size(hsize, 4'(haddr[NBL-1:0]), NBL);
  assign be      = be_full[NB-1:0];
  assign acc_raw = hsel & hready & htrans[1];

`ifdef AHB_SRAM_WB_ERR_EN
  err_state_e err_st;
  logic       addr_bad;
  logic       in_ok;

  assign addr_bad = ((haddr >> (AW + NBL)) != '0) || (32'(idx) >= DEPTH) || (32'(hsize) > NBL);
  assign in_ok    = (err_st == ERR_OK);
  // Transfers offered during either error cycle are dropped by the slave.
  assign acc      = acc_raw & in_ok & ~addr_bad;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      err_st    <= ERR_OK;
      hreadyout <= 1'b1;
      hresp     <= HRESP_OKAY;
    end else begin
      case (err_st)
        ERR_OK: begin
          if (acc_raw && addr_bad) begin
            err_st    <= ERR_FIRST;
            hreadyout <= 1'b0;
            hresp     <= HRESP_ERROR;
          end
        end
        ERR_FIRST: begin
          err_st    <= ERR_SECOND;
          hreadyout <= 1'b1;
          hresp     <= HRESP_ERROR;
        end
        default: begin
          err_st    <= ERR_OK;
          hreadyout <= 1'b1;
          hresp     <= HRESP_OKAY;
        end
      endcase
    end
  end
`else
  assign acc       = acc_raw;
  assign hreadyout = 1'b1;
  assign hresp     = HRESP_OKAY;
`endif

  assign rd_acc = acc & ~hwrite;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_dph  <= 1'b0;
      wr_dph  <= 1'b0;
      wr_addr <= '0;
      wr_be   <= '0;
    end else begin
      rd_dph <= rd_acc;
      wr_dph <= acc & hwrite;
      if (acc && hwrite) begin
        wr_addr <= idx;
        wr_be   <= be;
      end
    end
  end

  ahb_sram_wb_buf #(
    .DATA_W (DATA_W),
    .AW     (AW)
  ) u_buf (
    .clk      (clk),
    .rstn     (rstn),
    .ld       (wr_dph),
    .ld_addr  (wr_addr),
    .ld_be    (wr_be),
    .ld_data  (hwdata),
    .rd_acc   (rd_acc),
    .rd_addr  (idx),
    .wr_en    (buf_wr_en),
    .wr_addr  (buf_wr_addr),
    .wr_be    (buf_wr_be),
    .wr_data  (buf_wr_data),
    .fwd_be   (fwd_be),
    .fwd_data (fwd_data)
  );

  assign sram_en = rd_acc | buf_wr_en;

  spram_generic_wbe #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_sram (
    .clk  (clk),
    .en   (sram_en),
    .we   (buf_wr_en),
    .wbe  (buf_wr_be),
    .addr (rd_acc ? idx : buf_wr_addr),
    .din  (buf_wr_data),
    .dout (sram_dout)
  );

  always_comb begin
    hrdata = '0;
    if (rd_dph) begin
      for (int unsigned i = 0; i < NB; i++) begin
        hrdata[i*8 +: 8] = fwd_be[i] ? fwd_data[i*8 +: 8] : sram_dout[i*8 +: 8];
      end
    end
  end

endmodule

// File: tb/tb_ahb_sram_wb.sv
// Directed bench for ahb_sram_wb (DATA_W=32, DEPTH=1024); covers both
// AHB_SRAM_WB_ERR_EN builds.
module tb_ahb_sram_wb;
  import ahb_pkg::*;

  localparam logic [2:0] HBURST_INCR8 = 3'b101;

  logic        clk = 1'b0;
  logic        rstn;
  logic        hsel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [3:0]  hprot;
  logic        hwrite;
  logic [31:0] hwdata;
  logic        hready;
  logic        hreadyout;
  logic        hresp;
  logic [31:0] hrdata;

  always #5 clk = ~clk;
  assign hready = hreadyout;

  ahb_sram_wb #(
    .DATA_W  (32),
    .DEPTH   (1024),
    .HADDR_W (32)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .hsel      (hsel),
    .haddr     (haddr),
    .htrans    (htrans),
    .hsize     (hsize),
    .hburst    (hburst),
    .hprot     (hprot),
    .hwrite    (hwrite),
    .hwdata    (hwdata),
    .hready    (hready),
    .hreadyout (hreadyout),
    .hresp     (hresp),
    .hrdata    (hrdata)
  );

  int unsigned tests_run    = 0;
  int unsigned tests_failed = 0;
  int unsigned stall_cnt    = 0;
  logic [31:0] obs_rdata;
  logic        obs_ready;
  logic        obs_resp;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One bus cycle: drive address phase + hwdata for the previous beat, sample mid-cycle.
  task automatic beat(input logic sel, input logic [1:0] trans, input logic wr,
                      input logic [31:0] addr, input logic [2:0] size, input logic [31:0] wdata);
    hsel   = sel;
    htrans = trans;
    hwrite = wr;
    haddr  = addr;
    hsize  = size;
    hwdata = wdata;
    @(negedge clk);
    obs_rdata = hrdata;
    obs_ready = hreadyout;
    obs_resp  = hresp;
    if (!obs_ready) stall_cnt++;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic [31:0] wdata);
    beat(1'b0, HTRANS_IDLE, 1'b0, 32'h0, HSIZE_BYTE, wdata);
  endtask

  function automatic logic [31:0] bdat(input int unsigned i);
    return 32'hC0DE_0000 | (i * 32'h111);
  endfunction

  logic [1:0]  b_trans [11];
  logic [31:0] b_addr  [11];
  logic        prev_rd;
  int unsigned prev_i;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rstn = 1'b0; hsel = 1'b0; haddr = '0; htrans = HTRANS_IDLE; hsize = HSIZE_WORD;
    hburst = 3'b000; hprot = 4'h3; hwrite = 1'b0; hwdata = '0;
    #2;
    check_eq("rst_hreadyout", 32'(hreadyout), 32'd1);
    check_eq("rst_hresp", 32'(hresp), 32'd0);
    check_eq("rst_hrdata", hrdata, 32'h0);
    @(negedge clk); rstn = 1'b1;
    @(posedge clk); #1;

    // write then immediate read of the same word: served from the buffer
    beat(1'b1, HTRANS_NONSEQ, 1'b1, 32'h000, HSIZE_WORD, 32'h0);
    beat(1'b1, HTRANS_NONSEQ, 1'b0, 32'h000, HSIZE_WORD, 32'hA5A5A5A5);
    idle(32'h0);
    check_eq("raw_fwd_000", obs_rdata, 32'hA5A5A5A5);
    beat(1'b1, HTRANS_NONSEQ, 1'b0, 32'h000, HSIZE_WORD, 32'h0);
    idle(32'h0);
    check_eq("sram_rd_000", obs_rdata, 32'hA5A5A5A5);
    idle(32'h0);
    check_eq("hrdata_idle", obs_rdata, 32'h0);

    // word write, byte write, read back-to-back
    beat(1'b1, HTRANS_NONSEQ, 1'b1, 32'h010, HSIZE_WORD, 32'h0);
    beat(1'b1, HTRANS_NONSEQ, 1'b1, 32'h012, HSIZE_BYTE, 32'h11223344);
    beat(1'b1, HTRANS_NONSEQ, 1'b0, 32'h010, HSIZE_WORD, 32'hDDEEDDDD);
    idle(32'h0);
    check_eq("wbr_010", obs_rdata, 32'h11EE3344);

    // halfword write into upper half, forwarded on the very next read
    beat(1'b1, HTRANS_NONSEQ, 1'b1, 32'h020, HSIZE_WORD, 32'h0);
    idle(32'h12345678);
    beat(1'b1, HTRANS_NONSEQ, 1'b1, 32'h022, HSIZE_HALF, 32'h0);
    beat(1'b1, HTRANS_NONSEQ, 1'b0, 32'h020, HSIZE_WORD, 32'hBEEFCAFE);
    idle(32'h0);
    check_eq("half_fwd_020", obs_rdata, 32'hBEEF5678);
    beat(1'b1, HTRANS_NONSEQ, 1'b0, 32'h020, HSIZE_WORD, 32'h0);
    idle(32'h0);
    check_eq("half_mem_020", obs_rdata, 32'hBEEF5678);

    // preload 0x40..0x5C, then INCR8 read with BUSY beats
    for (int unsigned i = 0; i < 9; i++) begin
      if (i < 8) beat(1'b1, HTRANS_NONSEQ, 1'b1, 32'h40 + 4 * i, HSIZE_WORD, (i > 0) ? bdat(i - 1) : 32'h0);
      else       idle(bdat(7));
    end
    b_trans = '{HTRANS_NONSEQ, HTRANS_SEQ, HTRANS_BUSY, HTRANS_SEQ, HTRANS_SEQ, HTRANS_SEQ,
                HTRANS_BUSY, HTRANS_SEQ, HTRANS_SEQ, HTRANS_SEQ, HTRANS_IDLE};
    b_addr  = '{32'h40, 32'h44, 32'h48, 32'h48, 32'h4C, 32'h50,
                32'h54, 32'h54, 32'h58, 32'h5C, 32'h00};
    prev_rd = 1'b0;
    prev_i  = 0;
    hburst  = HBURST_INCR8;
    for (int unsigned k = 0; k < 11; k++) begin
      beat(b_trans[k] != HTRANS_IDLE, b_trans[k], 1'b0, b_addr[k], HSIZE_WORD, 32'h0);
      if (k > 0) check_eq($sformatf("incr8_beat%0d", k), obs_rdata, prev_rd ? bdat(prev_i) : 32'h0);
      prev_rd = b_trans[k][1];
      prev_i  = (b_addr[k] - 32'h40) >> 2;
    end
    hburst = 3'b000;
    check_eq("no_stall", stall_cnt, 0);

`ifdef AHB_SRAM_WB_ERR_EN
    beat(1'b1, HTRANS_NONSEQ, 1'b1, 32'h1000, HSIZE_WORD, 32'h0);
    idle(32'hDEADBEEF);
    check_eq("err_c1_ready", 32'(obs_ready), 32'd0);
    check_eq("err_c1_resp", 32'(obs_resp), 32'd1);
    beat(1'b1, HTRANS_NONSEQ, 1'b1, 32'h000, HSIZE_WORD, 32'h0);
    check_eq("err_c2_ready", 32'(obs_ready), 32'd1);
    check_eq("err_c2_resp", 32'(obs_resp), 32'd1);
    idle(32'h0BADF00D);
    check_eq("err_done_resp", 32'(obs_resp), 32'd0);
    beat(1'b1, HTRANS_NONSEQ, 1'b0, 32'h000, HSIZE_WORD, 32'h0);
    idle(32'h0);
    check_eq("err_mem_000", obs_rdata, 32'hA5A5A5A5);
`else
    beat(1'b1, HTRANS_NONSEQ, 1'b1, 32'h1000, HSIZE_WORD, 32'h0);
    idle(32'h0BADF00D);
    check_eq("alias_ready", 32'(obs_ready), 32'd1);
    check_eq("alias_resp", 32'(obs_resp), 32'd0);
    beat(1'b1, HTRANS_NONSEQ, 1'b0, 32'h000, HSIZE_WORD, 32'h0);
    idle(32'h0);
    check_eq("alias_mem_000", obs_rdata, 32'h0BADF00D);
    beat(1'b1, HTRANS_NONSEQ, 1'b1, 32'h004, HSIZE_DWORD, 32'h0);
    beat(1'b1, HTRANS_NONSEQ, 1'b0, 32'h004, HSIZE_WORD, 32'h76543210);
    idle(32'h0);
    check_eq("oversize_all_be", obs_rdata, 32'h76543210);
`endif
    stall_cnt = 0;

    // reset during a write data phase with a read queued behind it
    beat(1'b1, HTRANS_NONSEQ, 1'b1, 32'h030, HSIZE_WORD, 32'h0);
    idle(32'h33333333);
    beat(1'b1, HTRANS_NONSEQ, 1'b1, 32'h030, HSIZE_WORD, 32'h0);
    hsel = 1'b1; htrans = HTRANS_NONSEQ; hwrite = 1'b0; haddr = 32'h030;
    hsize = HSIZE_WORD; hwdata = 32'h44444444; rstn = 1'b0;
    @(negedge clk);
    check_eq("midrst_hrdata", hrdata, 32'h0);
    check_eq("midrst_ready", 32'(hreadyout), 32'd1);
    rstn = 1'b1;
    @(posedge clk); #1;
    idle(32'h0);
    check_eq("rst_discard_030", obs_rdata, 32'h33333333);
    beat(1'b1, HTRANS_NONSEQ, 1'b0, 32'h030, HSIZE_WORD, 32'h0);
    idle(32'h0);
    check_eq("rst_discard_030b", obs_rdata, 32'h33333333);
    check_eq("no_stall_end", stall_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
